// File: rtl/usr_sipo_rx.sv
// Serial-to-parallel frame receiver with a double-buffered valid/ready output register.
// Define USR_RX_PARITY_EN to add a trailing even-parity bit per word and the parity_err output.
module usr_sipo_rx #(
  parameter int unsigned size      = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            ser_in,
  input  logic            bit_en,
  input  logic            frame_start,
  output logic [size-1:0] par_out,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef USR_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun
);

  localparam int unsigned CntW = $clog2(size + 1);

`ifdef USR_RX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [size-1:0]   sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [size-1:0]   par_q, par_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;

  logic              deliver;
  logic [size-1:0]   word;
  logic              word_perr;
  logic [size-1:0]   sr_shift;
  logic [size-1:0]   sr_fresh;

  function automatic logic [size-1:0] shift_in(input logic [size-1:0] sr, input logic b);
    logic [size-1:0] res;
    if (MSB_FIRST) begin
      res = {sr[size-2:0], b};
    end else begin
      res = {b, sr[size-1:1]};
    end
    return res;
  endfunction

  assign sr_shift = shift_in(sr_q, ser_in);
  // A (re)started frame begins from an empty register so no stale bits survive.
  assign sr_fresh = shift_in('0, ser_in);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    deliver   = 1'b0;
    word      = sr_shift;
    word_perr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bit_en && frame_start) begin
          sr_d    = sr_fresh;
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (bit_en) begin
          if (frame_start) begin
            sr_d  = sr_fresh;
            cnt_d = CntW'(1);
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(size - 1)) begin
`ifdef USR_RX_PARITY_EN
              state_d = StParity;
`else
              deliver = 1'b1;
              word    = sr_shift;
              state_d = StIdle;
`endif
            end
          end
        end
      end
`ifdef USR_RX_PARITY_EN
      StParity: begin
        if (bit_en) begin
          if (frame_start) begin
            sr_d    = sr_fresh;
            cnt_d   = CntW'(1);
            state_d = StShift;
          end else begin
            deliver   = 1'b1;
            word      = sr_q;
            word_perr = (^sr_q) ^ ser_in;
            state_d   = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output buffer: a delivery may coincide with an accept and then replaces the word bubble-free.
  always_comb begin
    par_d   = par_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    if (deliver) begin
      if (!valid_q || out_ready) begin
        par_d   = word;
        perr_d  = word_perr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign par_out   = par_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
`ifdef USR_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_usr_sipo_rx.sv
// Self-checking bench for usr_sipo_rx: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared against a frame-level reference model.
module tb_usr_sipo_rx;

  localparam int unsigned SIZE = 4;

  logic clk = 1'b0;
  logic clr;
  logic ser_in, bit_en, frame_start, out_ready;
  logic [SIZE-1:0] par_out [2];
  logic            out_valid [2];
  logic            overrun [2];
  logic            parity_err [2];

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current frame, plus expected output registers per instance.
  bit              q[$];
  logic [SIZE-1:0] e_par [2];
  bit              e_valid [2];
  bit              e_ovr [2];
  bit              e_perr [2];

  always #5 clk = ~clk;

  usr_sipo_rx #(.size(SIZE), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en), .frame_start(frame_start),
    .par_out(par_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
`ifdef USR_RX_PARITY_EN
    .parity_err(parity_err[0]),
`endif
    .overrun(overrun[0])
  );

  usr_sipo_rx #(.size(SIZE), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .ser_in(ser_in), .bit_en(bit_en), .frame_start(frame_start),
    .par_out(par_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
`ifdef USR_RX_PARITY_EN
    .parity_err(parity_err[1]),
`endif
    .overrun(overrun[1])
  );

`ifndef USR_RX_PARITY_EN
  assign parity_err[0] = 1'b0;
  assign parity_err[1] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d par_out", ctx, k), 32'(par_out[k]), 32'(e_par[k]));
      chk($sformatf("%s u%0d out_valid", ctx, k), 32'(out_valid[k]), 32'(e_valid[k]));
      chk($sformatf("%s u%0d overrun", ctx, k), 32'(overrun[k]), 32'(e_ovr[k]));
`ifdef USR_RX_PARITY_EN
      chk($sformatf("%s u%0d parity_err", ctx, k), 32'(parity_err[k]), 32'(e_perr[k]));
`endif
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      e_par[k] = '0; e_valid[k] = 1'b0; e_ovr[k] = 1'b0; e_perr[k] = 1'b0;
    end
  endtask

  // Instance 0 puts the first received bit in the MSB, instance 1 in the LSB.
  function automatic logic [SIZE-1:0] word_of(input int k);
    logic [SIZE-1:0] w = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (k == 0) w[SIZE-1-i] = q[i];
      else        w[i]        = q[i];
    end
    return w;
  endfunction

  task automatic model_edge(input bit fs, input bit be, input bit si, input bit rdy);
    bit              deliver = 1'b0;
    bit              perr = 1'b0;
    logic [SIZE-1:0] w [2];
    w[0] = '0; w[1] = '0;
    if (be) begin
      if (fs) begin
        q.delete();
        q.push_back(si);
      end else if (q.size() == SIZE) begin
        // Only reachable with parity: this bit is the parity bit.
        w[0] = word_of(0); w[1] = word_of(1);
        perr = si;
        foreach (q[i]) perr = perr ^ q[i];
        deliver = 1'b1;
        q.delete();
      end else if (q.size() > 0) begin
        q.push_back(si);
`ifndef USR_RX_PARITY_EN
        if (q.size() == SIZE) begin
          w[0] = word_of(0); w[1] = word_of(1);
          deliver = 1'b1;
          q.delete();
        end
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (deliver) begin
        if (!e_valid[k] || rdy) begin
          e_par[k] = w[k]; e_valid[k] = 1'b1; e_perr[k] = perr;
        end else begin
          e_ovr[k] = 1'b1;
        end
      end else if (e_valid[k] && rdy) begin
        e_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic tick(input string tag, input bit fs, input bit be, input bit si, input bit rdy);
    frame_start = fs; bit_en = be; ser_in = si; out_ready = rdy;
    @(posedge clk);
    model_edge(fs, be, si, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_clr();
    #2 clr = 1'b1;
    #1 model_reset();
    check_all("clr");
    clr = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [SIZE-1:0] w, input bit rdy_early,
                           input bit rdy_last, input bit par_bad);
    bit r;
    for (int i = 0; i < SIZE; i++) begin
`ifdef USR_RX_PARITY_EN
      r = rdy_early;
`else
      r = (i == SIZE - 1) ? rdy_last : rdy_early;
`endif
      tick(tag, i == 0, 1'b1, w[SIZE-1-i], r);
    end
`ifdef USR_RX_PARITY_EN
    tick(tag, 1'b0, 1'b1, (^w) ^ par_bad, rdy_last);
`else
    if (par_bad) $display("note: parity disabled, par_bad ignored");
`endif
  endtask

  initial begin
    clr = 1'b1; ser_in = 1'b0; bit_en = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #1 clr = 1'b0;

    // bit_en in idle without frame_start is ignored
    for (int i = 0; i < 3; i++) tick("idle_noise", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("idle_noise valid", 32'(out_valid[0]), 32'd0);

    send_word("basic", 4'b1011, 1'b1, 1'b1, 1'b0);
    chk("basic msb word", 32'(par_out[0]), 32'hB);
    chk("basic lsb word", 32'(par_out[1]), 32'hD);
    chk("basic valid", 32'(out_valid[0]), 32'd1);
    tick("accept", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("accept valid", 32'(out_valid[0]), 32'd0);

    send_word("ovr_a", 4'hA, 1'b0, 1'b0, 1'b0);
    send_word("ovr_5", 4'h5, 1'b0, 1'b0, 1'b0);
    chk("ovr held word", 32'(par_out[0]), 32'hA);
    chk("ovr flag", 32'(overrun[0]), 32'd1);
    tick("ovr_drain", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr drain valid", 32'(out_valid[0]), 32'd0);
    chk("ovr sticky", 32'(overrun[0]), 32'd1);

    send_word("same_a", 4'h3, 1'b0, 1'b0, 1'b0);
    send_word("same_b", 4'hC, 1'b0, 1'b1, 1'b0);
    chk("same-cycle word", 32'(par_out[0]), 32'hC);
    chk("same-cycle valid", 32'(out_valid[0]), 32'd1);

    // restart on the third bit: word is that bit plus the next three
    tick("restart", 1'b1, 1'b1, 1'b0, 1'b1);
    tick("restart", 1'b0, 1'b1, 1'b1, 1'b1);
    tick("restart", 1'b1, 1'b1, 1'b1, 1'b1);
    tick("restart", 1'b0, 1'b1, 1'b0, 1'b1);
    tick("restart", 1'b0, 1'b1, 1'b0, 1'b1);
    tick("restart", 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef USR_RX_PARITY_EN
    tick("restart", 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    chk("restart word", 32'(par_out[0]), 32'h9);

    tick("midclr", 1'b1, 1'b1, 1'b1, 1'b1);
    tick("midclr", 1'b0, 1'b1, 1'b1, 1'b1);
    pulse_clr();
    chk("clr overrun", 32'(overrun[0]), 32'd0);
    send_word("post_clr", 4'h6, 1'b1, 1'b1, 1'b0);
    chk("post_clr word", 32'(par_out[0]), 32'h6);

`ifdef USR_RX_PARITY_EN
    send_word("par_ok", 4'b1011, 1'b1, 1'b1, 1'b0);
    chk("par_ok perr", 32'(parity_err[0]), 32'd0);
    send_word("par_bad", 4'b1011, 1'b1, 1'b1, 1'b1);
    chk("par_bad perr", 32'(parity_err[0]), 32'd1);
    chk("par_bad word", 32'(par_out[0]), 32'hB);
`endif

    for (int n = 0; n < 600; n++) begin
      tick("random", $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) pulse_clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usr_sipo_rx.md
# usr_sipo_rx

Serial-to-parallel frame receiver at the far end of the universal shift register's serial output. It samples a strobed serial bit stream, reassembles `size`-bit words in MSB-first or LSB-first order, and presents each completed word on a registered, double-buffered parallel output with a valid/ready handshake. Overruns are flagged when the downstream consumer stalls.

## Interface
- `size`, 4: data word width in bits; legal range is 2 or greater.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `par_out[size-1]`; 0 means it lands in `par_out[0]`.

- `clk`  input  1  sole clock; everything is sampled on the rising edge.
- `clr`  input  1  asynchronous, active-high reset.
- `ser_in`  input  1  serial data; sampled only when `bit_en`=1.
- `bit_en`  input  1  bit strobe; one data bit per cycle in which it is high.
- `frame_start`  input  1  qualifies the current `bit_en` bit as the first bit of a word.
- `par_out`  output  size  last completed word, held stable while `out_valid`=1.
- `out_valid`  output  1  `par_out` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts the word when `out_valid` and `out_ready` are both high.
- `overrun`  output  1  sticky flag; a completed word was dropped.
- `parity_err`  output  1  parity check result for `par_out`; present only with `USR_RX_PARITY_EN`.

## Operation
- Reset (`clr`=1, any time, mid-frame included): state=IDLE, shift register=0, bit counter=0, `par_out`=0, `out_valid`=0, `overrun`=0, `parity_err`=0. Any partial word is discarded.
- States:
  - IDLE, SHIFT, plus PARITY when the macro is defined.
- IDLE:
  - `bit_en`=1 with `frame_start`=1: shift in `ser_in`, set counter=1, go to SHIFT.
  - `bit_en` without `frame_start`: ignored.
- SHIFT:
  - On each `bit_en`, shift in `ser_in` and increment the counter.
  - If `frame_start`=1 with `bit_en`: restart. The partial word is discarded, the bit is taken as bit 1, and counter=1.
  - The bit that brings the counter to `size` completes the word. Go to PARITY when the macro is enabled; otherwise deliver the word and go to IDLE.
- Shift rule:
  - `MSB_FIRST`=1: `sr <= {sr[size-2:0], ser_in}`.
  - `MSB_FIRST`=0: `sr <= {ser_in, sr[size-1:1]}`.
  - The final word is the shift register value including the completing bit.
- Deliver, evaluated in the completion cycle:
  - `out_valid`=0, or `out_ready`=1: load `par_out`, set `out_valid`=1.
  - `out_valid`=1 and `out_ready`=0: drop the new word, keep the old `par_out`, set `overrun`=1.
- Handshake:
  - When `out_valid` and `out_ready` are both high and no word completes in that cycle, `out_valid` goes to 0 on the next edge.
  - A word completing in the same cycle as an accept keeps `out_valid` at 1 with the new data; there is no bubble.
- `overrun` is cleared only by `clr`.
- Bits arriving while a completed word waits are still received, because the shift register and the output register are independent.

## Timing
- A completing bit sampled at edge N sets `par_out`/`out_valid` valid after edge N. Latency is 0 extra cycles after the last bit.
- Back-to-back `bit_en` every cycle is supported. The minimum word period is `size` cycles, or `size`+1 with parity.
- All outputs are registered, with no combinational path from inputs to outputs.
- `out_ready` is sampled only while `out_valid`=1.

## Configuration
- `USR_RX_PARITY_EN` defined:
  - After the `size` data bits, state PARITY waits for one more `bit_en` carrying an even-parity bit.
  - `frame_start` on that bit restarts the frame as in SHIFT, and the pending word is discarded.
  - Delivery happens on the parity bit, with `parity_err` = XOR of the data bits XOR the parity bit, registered together with `par_out`.
  - Words with a parity error are still delivered.
- Not defined: the PARITY state and the `parity_err` port do not exist, and delivery happens on data bit `size`.

## Test plan
- Basic receive: `size`=4, `MSB_FIRST`=1. Bits 1,0,1,1 on consecutive `bit_en` cycles, `frame_start` on the first bit -> `par_out`=4'b1011 and `out_valid`=1 after the 4th edge.
- Bit order: `MSB_FIRST`=0 with the same stream -> `par_out`=4'b1101. `bit_en`=1 in IDLE without `frame_start` -> no state change.
- Handshake and overrun:
  - Hold `out_ready`=0 and send two words 0xA, 0x5 -> `par_out` stays 0xA, `overrun`=1.
  - Then set `out_ready`=1 -> `out_valid`=0 next cycle; `overrun` stays 1 until `clr`.
  - A word completing in the same cycle as an accept -> `out_valid` stays 1 with the new word.
- Restart and reset:
  - `frame_start` on the 3rd bit of a frame -> the word consists of that bit plus the next 3 bits.
  - `clr` pulse between edges mid-frame -> all outputs 0 immediately; the next full frame is received correctly.
- Parity, with the macro: data 4'b1011 plus parity 1 -> `parity_err`=0. The same data with parity 0 -> `parity_err`=1, and the word is still delivered.
